video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 39 +++
 rtl/video_pattern_gen.sv | 58 +++++
 rtl/video_timing_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing defaults, pattern encodings and colour helpers
// for the video timing generator.
package video_timing_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps
    // to r = ~idx[1], g = ~idx[2], b = ~idx[0].
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = {8{~idx[1]}};
        c.g = {8{~idx[2]}};
        c.b = {8{~idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern colour generator: colour bars, checkerboard,
// gradient and solid blue, selected per frame by the timing generator.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [CNT_W-1:0] x,
    input  logic [7:0]       y,
    input  logic [7:0]       frame_cnt,
    input  pattern_t         pattern,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b
);

    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [CNT_W-1:0] bar_full;
    logic [2:0]       bar_idx;
    rgb_t             bar;

    always_comb begin
        bar_full = x / CNT_W'(BAR_W);
        // Clamp so any remainder pixels past the eighth bar stay black
        bar_idx  = (bar_full > CNT_W'(7)) ? 3'd7 : bar_full[2:0];
        bar      = bar_colour(bar_idx);
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        case (pattern)
            PAT_BARS: begin
                r = bar.r;
                g = bar.g;
                b = bar.b;
            end
            PAT_CHECK: begin
                if (!(x[5] ^ y[5])) begin
                    r = 8'hFF;
                    g = 8'hFF;
                    b = 8'hFF;
                end
            end
            PAT_GRAD: begin
                r = x[7:0];
                g = y;
                b = frame_cnt;
            end
            PAT_SOLID: begin
                b = 8'hFF;
            end
            default: begin
                r = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/DE decode and a registered
// output stage carrying sync, DE, coordinates and test-pattern pixels.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             I_rgb_clk,
    input  logic             I_rst_n,
    input  logic [1:0]       I_pattern_sel,
    output logic             O_rgb_hs,
    output logic             O_rgb_vs,
    output logic             O_rgb_de,
    output logic [7:0]       O_rgb_r,
    output logic [7:0]       O_rgb_g,
    output logic [7:0]       O_rgb_b,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [7:0]       frame_cnt;
    pattern_t         pattern_q;

    logic             h_last;
    logic             v_last;
    logic             first_pix_p0;
    logic             de_p0;
    logic             hs_p0;
    logic             vs_p0;
    pattern_t         pattern_p0;
    logic [CNT_W-1:0] x_p0;
    logic [CNT_W-1:0] y_p0;
    logic [7:0]       r_p0;
    logic [7:0]       g_p0;
    logic [7:0]       b_p0;

    // Stage p0: counter state and combinational decode
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= 8'h00;
            pattern_q <= PAT_BARS;
        end else begin
            if (first_pix_p0)
                pattern_q <= pattern_t'(I_pattern_sel);
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        h_last       = (h_cnt == H_LAST);
        v_last       = (v_cnt == V_LAST);
        first_pix_p0 = (h_cnt == '0) && (v_cnt == '0);
        de_p0        = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_p0        = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        vs_p0        = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
        // Pixel (0,0) already uses the newly sampled selection so the whole frame matches
        pattern_p0   = first_pix_p0 ? pattern_t'(I_pattern_sel) : pattern_q;
        x_p0         = de_p0 ? h_cnt : '0;
        y_p0         = de_p0 ? v_cnt : '0;
    end

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .x         (x_p0),
        .y         (y_p0[7:0]),
        .frame_cnt (frame_cnt),
        .pattern   (pattern_p0),
        .r         (r_p0),
        .g         (g_p0),
        .b         (b_p0)
    );

    // Stage p1: registered outputs, all aligned one cycle after the counters
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rgb_hs      <= ~HS_POL;
            O_rgb_vs      <= ~VS_POL;
            O_rgb_de      <= 1'b0;
            O_rgb_r       <= 8'h00;
            O_rgb_g       <= 8'h00;
            O_rgb_b       <= 8'h00;
            O_x           <= '0;
            O_y           <= '0;
            O_frame_start <= 1'b0;
        end else begin
            O_rgb_hs      <= hs_p0;
            O_rgb_vs      <= vs_p0;
            O_rgb_de      <= de_p0;
            O_rgb_r       <= de_p0 ? r_p0 : 8'h00;
            O_rgb_g       <= de_p0 ? g_p0 : 8'h00;
            O_rgb_b       <= de_p0 ? b_p0 : 8'h00;
            O_x           <= x_p0;
            O_y           <= y_p0;
            O_frame_start <= first_pix_p0;
        end
    end

endmodule
